// File: rtl/mult_pkg.sv
// ============================================================================
// Module : mult_pkg
// Brief  : Shared encodings for the sequential radix-4 Booth multiplier.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_P1   = 3'd1,
        SEL_P2   = 3'd2,
        SEL_M1   = 3'd3,
        SEL_M2   = 3'd4
    } booth_sel_e;

endpackage

`default_nettype wire

// File: rtl/booth_r4_recode.sv
// ============================================================================
// Module : booth_r4_recode
// Brief  : Radix-4 Booth recoder, {b[2i+1], b[2i], b[2i-1]} -> partial-product select.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module booth_r4_recode
    import mult_pkg::*;
(
    input  logic [2:0]  i_window,
    output booth_sel_e  o_sel
);

    always_comb begin
        o_sel = SEL_ZERO;
        case (i_window)
            3'b000, 3'b111: o_sel = SEL_ZERO;
            3'b001, 3'b010: o_sel = SEL_P1;
            3'b011:         o_sel = SEL_P2;
            3'b100:         o_sel = SEL_M2;
            3'b101, 3'b110: o_sel = SEL_M1;
            default:        o_sel = SEL_ZERO;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seq_booth_multiplier.sv
// ============================================================================
// Module : seq_booth_multiplier
// Brief  : Iterative radix-4 Booth multiplier, one Booth digit per cycle, valid/ready I/O.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_booth_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 a_signed,
    input  logic                 b_signed,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int EXT   = WIDTH + 2;
    localparam int ITERS = EXT / 2;
    localparam int ACC_W = EXT + 2;
    localparam int CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(ITERS - 1);

    logic [1:0]          r_state;
    logic [EXT-1:0]      r_mcand;
    logic [EXT-1:0]      r_hi;
    logic [EXT-1:0]      r_lo;
    logic                r_qm1;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0]  r_product;
    logic                r_out_valid;

    logic [EXT-1:0]      w_a_ext;
    logic [EXT-1:0]      w_b_ext;
    logic [2:0]          w_window;
    booth_sel_e          w_sel;
    logic [ACC_W-1:0]    w_m;
    logic [ACC_W-1:0]    w_addend;
    logic [ACC_W-1:0]    w_sum;

    assign w_a_ext  = {{2{a_signed & a[WIDTH-1]}}, a};
    assign w_b_ext  = {{2{b_signed & b[WIDTH-1]}}, b};
    assign w_window = {r_lo[1:0], r_qm1};

    booth_r4_recode u_recode (
        .i_window (w_window),
        .o_sel    (w_sel)
    );

    // Two guard bits above the EXT-bit accumulator absorb +/-2M without overflow.
    assign w_m = {{2{r_mcand[EXT-1]}}, r_mcand};

    always_comb begin
        w_addend = '0;
        case (w_sel)
            SEL_ZERO: w_addend = '0;
            SEL_P1:   w_addend = w_m;
            SEL_P2:   w_addend = {w_m[ACC_W-2:0], 1'b0};
            SEL_M1:   w_addend = -w_m;
            SEL_M2:   w_addend = -{w_m[ACC_W-2:0], 1'b0};
            default:  w_addend = '0;
        endcase
    end

    assign w_sum = {{2{r_hi[EXT-1]}}, r_hi} + w_addend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mcand     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_qm1       <= 1'b0;
            r_cnt       <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= ST_BUSY;
                        r_mcand <= w_a_ext;
                        r_hi    <= '0;
                        r_lo    <= w_b_ext;
                        r_qm1   <= 1'b0;
                        r_cnt   <= c_CNT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        // Arithmetic shift of {acc, multiplier} right by one Booth digit.
                        r_hi  <= w_sum[ACC_W-1:2];
                        r_lo  <= {w_sum[1:0], r_lo[EXT-1:2]};
                        r_qm1 <= r_lo[1];
                        if (r_cnt == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // First DONE cycle registers the product; abort wins over a handshake.
                    if (abort) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end else if (!r_out_valid) begin
                        r_product   <= {r_hi[WIDTH-3:0], r_lo};
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign product   = r_product;

endmodule

`default_nettype wire

// File: tb/tb_seq_booth_multiplier.sv
// ============================================================================
// Module : tb_seq_booth_multiplier
// Brief  : Self-checking bench for seq_booth_multiplier against a wide-arithmetic model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seq_booth_multiplier;

    localparam int W     = 64;
    localparam int ITERS = (W + 2) / 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           a_signed;
    logic           b_signed;
    logic           abort;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;

    int n_checks = 0;
    int n_errors = 0;

    seq_booth_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    // Reference: interpret operands per mode, multiply exactly, keep the low 2W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic xs, input logic ys);
        logic signed [2*W+3:0] xa;
        logic signed [2*W+3:0] ya;
        logic signed [2*W+3:0] p;
        xa = xs ? {{(W+4){x[W-1]}}, x} : {{(W+4){1'b0}}, x};
        ya = ys ? {{(W+4){y[W-1]}}, y} : {{(W+4){1'b0}}, y};
        p  = xa * ya;
        return p[2*W-1:0];
    endfunction

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic tas, input logic tbs, output logic accepted);
        int guard;
        guard = 0;
        @(negedge clk);
        a = ta; b = tb_v; a_signed = tas; b_signed = tbs; in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        accepted = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble operands so late sampling would corrupt the result.
        a = ~ta; b = ~tb_v; a_signed = ~tas; b_signed = ~tbs;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic handshake(input int hold);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tas,
                          input logic tbs, input int hold, output logic [2*W-1:0] prod,
                          output int lat, output logic got);
        logic acc;
        start_op(ta, tb_v, tas, tbs, acc);
        wait_valid(lat);
        got  = out_valid & acc;
        prod = product;
        handshake(hold);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid);
        end
        n_checks++;
        if (product !== '0) begin
            n_errors++; $display("FAIL reset_product: got %h required 0", product);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0]   va [7];
        logic [W-1:0]   vb [7];
        logic           vas[7];
        logic           vbs[7];
        logic [2*W-1:0] prod;
        logic [2*W-1:0] exp;
        int             lat;
        logic           got;
        va[0] = 64'd10;                vb[0] = 64'd5;                 vas[0] = 1; vbs[0] = 1;
        va[1] = -64'sd8;               vb[1] = 64'd6;                 vas[1] = 1; vbs[1] = 1;
        va[2] = -64'sd12;              vb[2] = -64'sd4;               vas[2] = 1; vbs[2] = 1;
        va[3] = 64'd0;                 vb[3] = '1;                    vas[3] = 0; vbs[3] = 0;
        va[4] = '1;                    vb[4] = '1;                    vas[4] = 0; vbs[4] = 0;
        va[5] = 64'h8000_0000_0000_0000; vb[5] = 64'h8000_0000_0000_0000; vas[5] = 1; vbs[5] = 1;
        va[6] = '1;                    vb[6] = '1;                    vas[6] = 1; vbs[6] = 0;
        for (int i = 0; i < 7; i++) begin
            exp = ref_mul(va[i], vb[i], vas[i], vbs[i]);
            run_op(va[i], vb[i], vas[i], vbs[i], 0, prod, lat, got);
            n_checks++;
            if (!got || lat != ITERS + 1) begin
                n_errors++;
                $display("FAIL directed_latency[%0d]: got %0d edges (valid=%0b) required %0d", i, lat, got, ITERS + 1);
            end
            n_checks++;
            if (prod !== exp) begin
                n_errors++; $display("FAIL directed_product[%0d]: got %h required %h", i, prod, exp);
            end
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL directed_idle[%0d]: in_ready=%0b out_valid=%0b required 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic           acc;
        logic [2*W-1:0] exp;
        int             lat;
        exp = ref_mul(64'd123456789, -64'sd987654321, 1'b0, 1'b1);
        start_op(64'd123456789, -64'sd987654321, 1'b0, 1'b1, acc);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 64'd99; b = 64'd77;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== exp) begin
                n_errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%0b ready=%0b product=%h required 1/0/%h",
                         i, out_valid, in_ready, product, exp);
            end
        end
        in_valid = 1'b0;
        handshake(0);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== exp) begin
            n_errors++;
            $display("FAIL backpressure_release: valid=%0b ready=%0b product=%h required 0/1/%h",
                     out_valid, in_ready, product, exp);
        end
    endtask

    task automatic test_abort_idle();
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_idle: ready=%0b valid=%0b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_abort();
        logic           acc;
        logic           seen;
        logic [2*W-1:0] prod;
        int             lat;
        logic           got;
        start_op(64'd1000, 64'd2000, 1'b0, 1'b0, acc);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL abort_to_idle: in_ready=%0b required 1", in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_errors++; $display("FAIL abort_no_output: out_valid seen=1 required 0");
        end
        run_op(64'd3, 64'd7, 1'b0, 1'b0, 0, prod, lat, got);
        n_checks++;
        if (!got || prod !== 128'd21 || lat != ITERS + 1) begin
            n_errors++;
            $display("FAIL abort_recovery: product=%h lat=%0d valid=%0b required 21/%0d/1", prod, lat, got, ITERS + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic           acc;
        logic [2*W-1:0] exp1;
        logic [2*W-1:0] exp2;
        int             lat;
        exp1 = ref_mul(64'hDEAD_BEEF_0000_1234, 64'd55, 1'b1, 1'b0);
        exp2 = ref_mul(-64'sd9, 64'd11, 1'b1, 1'b1);
        start_op(64'hDEAD_BEEF_0000_1234, 64'd55, 1'b1, 1'b0, acc);
        wait_valid(lat);
        n_checks++;
        if (product !== exp1) begin
            n_errors++; $display("FAIL b2b_first: got %h required %h", product, exp1);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        a = -64'sd9; b = 64'd11; a_signed = 1'b1; b_signed = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++; $display("FAIL b2b_same_edge_ready: got %0b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_idle_gap: ready=%0b valid=%0b required 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++; $display("FAIL b2b_second_accept: in_ready=%0b required 0", in_ready);
        end
        wait_valid(lat);
        n_checks++;
        if (!out_valid || lat != ITERS + 1 || product !== exp2) begin
            n_errors++;
            $display("FAIL b2b_second: product=%h lat=%0d required %h/%0d", product, lat, exp2, ITERS + 1);
        end
        handshake(0);
    endtask

    task automatic test_async_reset();
        logic           acc;
        logic [2*W-1:0] prod;
        logic [2*W-1:0] exp;
        int             lat;
        logic           got;
        start_op(64'd777, 64'd888, 1'b0, 1'b0, acc);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            n_errors++;
            $display("FAIL async_reset: ready=%0b valid=%0b product=%h required 1/0/0", in_ready, out_valid, product);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp = ref_mul(-64'sd31415, 64'd27182, 1'b1, 1'b0);
        run_op(-64'sd31415, 64'd27182, 1'b1, 1'b0, 1, prod, lat, got);
        n_checks++;
        if (!got || prod !== exp || lat != ITERS + 1) begin
            n_errors++;
            $display("FAIL async_reset_recovery: product=%h lat=%0d required %h/%0d", prod, lat, exp, ITERS + 1);
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic           ras;
        logic           rbs;
        logic [2*W-1:0] prod;
        logic [2*W-1:0] exp;
        int             lat;
        logic           got;
        for (int i = 0; i < 30; i++) begin
            ra  = {$urandom(), $urandom()};
            rb  = {$urandom(), $urandom()};
            ras = 1'($urandom_range(0, 1));
            rbs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 1) ? '1 : 64'h8000_0000_0000_0000;
            if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 1) ? '1 : 64'h7FFF_FFFF_FFFF_FFFF;
            exp = ref_mul(ra, rb, ras, rbs);
            run_op(ra, rb, ras, rbs, $urandom_range(0, 3), prod, lat, got);
            n_checks++;
            if (!got || prod !== exp || lat != ITERS + 1) begin
                n_errors++;
                $display("FAIL random[%0d]: a=%h b=%h modes=%0b%0b product=%h lat=%0d required %h/%0d",
                         i, ra, rb, ras, rbs, prod, lat, exp, ITERS + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_abort_idle();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
